// File: rtl/lcb_pkg.sv
// Shared definitions for the LCB receive path: FSM states, error-flag bit
// positions, bus widths, the packed Orbita word layout and a constant
// shift-add multiplier used for group-buffer address generation.
package lcb_pkg;

    localparam int unsigned LCB_ADDR_W = 10;
    localparam int unsigned ORB_WORD_W = 12;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned RQ_W       = 5;
    localparam int unsigned ERR_W      = 3;
    localparam int unsigned GAP_CNT_W  = 16;

    localparam int unsigned ERR_SHORT = 0;
    localparam int unsigned ERR_OVF   = 1;
    localparam int unsigned ERR_NIB   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LO,
        WAIT_HI,
        TRAIL,
        DONE
    } lcb_state_e;

    // Orbita word: low nibble of the high byte above the full low byte.
    typedef struct packed {
        logic [3:0]        hi_nib;
        logic [BYTE_W-1:0] lo;
    } orb_word_t;

    // a*k for a constant k (k <= 31) as a sum of shifted copies of a.
    function automatic logic [LCB_ADDR_W-1:0] mul_const(
        input logic [RQ_W-1:0] a,
        input int unsigned     k
    );
        logic [LCB_ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            if (k[i]) begin
                acc = acc + (LCB_ADDR_W'(a) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/lcb_gap_timer.sv
// Inter-byte silence timer.
//   clk, reset : clock, async active-high reset
//   clr        : zero the counter this cycle (byte strobe or idle)
//   en         : count while a packet is open
//   timeout_c  : combinational, high when the counter sits at GAP_CYCLES-1
//                with no clear pending this cycle
module lcb_gap_timer
    import lcb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 400
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout_c
);

    logic [GAP_CNT_W-1:0] cnt_q;
    logic [GAP_CNT_W-1:0] cnt_d;

    // Next count: clear has priority so a strobe on the timeout cycle wins.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + GAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_c = en & ~clr & (cnt_q == GAP_CNT_W'(GAP_CYCLES - 1));

endmodule

// File: rtl/lcb_rx_packer.sv
// Receive-side packer for one LCB channel: pairs UART bytes into 12-bit
// Orbita words, generates group-buffer write addresses from the latched
// request number, closes packets on inter-byte silence and reports a
// per-packet error summary.
//   clk, reset : 80 MHz clock, async active-high reset
//   rxData     : byte from the UART receiver
//   rxValid    : level, rising edge marks a new byte
//   rqNumber   : current request number (latched on the first byte)
//   wrdOut     : packed word            (registered)
//   wrdAddr    : group-buffer address   (registered)
//   wren       : one-cycle write strobe (registered)
//   pktDone    : one-cycle packet-close pulse (registered)
//   pktErr     : {nibble, overflow, short}, valid with pktDone (registered)
module lcb_rx_packer
    import lcb_pkg::*;
#(
    parameter int unsigned BYTES      = 14,
    parameter int unsigned GAP_CYCLES = 400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     rxData,
    input  logic                  rxValid,
    input  logic [RQ_W-1:0]       rqNumber,
    output logic [ORB_WORD_W-1:0] wrdOut,
    output logic [LCB_ADDR_W-1:0] wrdAddr,
    output logic                  wren,
    output logic                  pktDone,
    output logic [ERR_W-1:0]      pktErr
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned HALF  = BYTES / 2;

    lcb_state_e            state_q,    state_d;
    logic                  rx_valid_q;
    logic                  pending_q,  pending_d;
    logic [BYTE_W-1:0]     lo_q,       lo_d;
    logic [RQ_W-1:0]       rq_q,       rq_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [ERR_W-1:0]      flags_q,    flags_d;
    logic [ORB_WORD_W-1:0] wrd_out_q,  wrd_out_d;
    logic [LCB_ADDR_W-1:0] wrd_addr_q, wrd_addr_d;
    logic                  wren_q,     wren_d;
    logic                  pkt_done_q, pkt_done_d;
    logic [ERR_W-1:0]      pkt_err_q,  pkt_err_d;

    logic                  stb_c;
    logic                  take_c;
    logic                  timeout_c;
    logic                  gap_en_c;
    logic                  gap_clr_c;
    logic [LCB_ADDR_W-1:0] base_addr_c;
    orb_word_t             word_c;

    assign stb_c = rxValid & ~rx_valid_q;
    // In IDLE a byte strobed during DONE is still accepted while rxValid holds.
    assign take_c = stb_c | (pending_q & rxValid);

    assign gap_en_c  = (state_q == WAIT_LO) || (state_q == WAIT_HI) || (state_q == TRAIL);
    assign gap_clr_c = stb_c || (state_q == IDLE);

    assign base_addr_c = mul_const(rq_q, HALF);

    always_comb begin
        word_c.hi_nib = rxData[3:0];
        word_c.lo     = lo_q;
    end

    lcb_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (gap_clr_c),
        .en        (gap_en_c),
        .timeout_c (timeout_c)
    );

    // Packet FSM and registered output generation.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q & rxValid;
        lo_d       = lo_q;
        rq_d       = rq_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        flags_d    = flags_q;
        wrd_out_d  = wrd_out_q;
        wrd_addr_d = wrd_addr_q;
        wren_d     = 1'b0;
        pkt_done_d = 1'b0;
        pkt_err_d  = '0;

        case (state_q)
            IDLE: begin
                if (take_c) begin
                    lo_d       = rxData;
                    rq_d       = rqNumber;
                    byte_cnt_d = CNT_W'(1);
                    word_idx_d = '0;
                    flags_d    = '0;
                    pending_d  = 1'b0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (stb_c) begin
                    wrd_out_d  = word_c;
                    wrd_addr_d = base_addr_c + LCB_ADDR_W'(word_idx_q);
                    wren_d     = 1'b1;
                    word_idx_d = word_idx_q + IDX_W'(1);
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (rxData[7:4] != 4'h0) begin
                        flags_d[ERR_NIB] = 1'b1;
                    end
                    if ((byte_cnt_q + CNT_W'(1)) == CNT_W'(BYTES)) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = WAIT_LO;
                    end
                end else if (timeout_c) begin
                    flags_d[ERR_SHORT] = 1'b1;
                    state_d            = DONE;
                end
            end
            WAIT_LO: begin
                if (stb_c) begin
                    lo_d       = rxData;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    state_d    = WAIT_HI;
                end else if (timeout_c) begin
                    flags_d[ERR_SHORT] = 1'b1;
                    state_d            = DONE;
                end
            end
            TRAIL: begin
                if (stb_c) begin
                    flags_d[ERR_OVF] = 1'b1;
                end else if (timeout_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (stb_c) begin
                    pending_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Summary is registered on entry so it coincides with the DONE cycle.
        if ((state_d == DONE) && (state_q != DONE)) begin
            pkt_done_d = 1'b1;
            pkt_err_d  = flags_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            lo_q       <= '0;
            rq_q       <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            flags_q    <= '0;
            wrd_out_q  <= '0;
            wrd_addr_q <= '0;
            wren_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rxValid;
            pending_q  <= pending_d;
            lo_q       <= lo_d;
            rq_q       <= rq_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            flags_q    <= flags_d;
            wrd_out_q  <= wrd_out_d;
            wrd_addr_q <= wrd_addr_d;
            wren_q     <= wren_d;
            pkt_done_q <= pkt_done_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    assign wrdOut  = wrd_out_q;
    assign wrdAddr = wrd_addr_q;
    assign wren    = wren_q;
    assign pktDone = pkt_done_q;
    assign pktErr  = pkt_err_q;

endmodule

// File: tb/tb_lcb_rx_packer.sv
// Scoreboard bench for lcb_rx_packer: the stimulus process pushes expected
// writes and packet-close events, a negedge monitor pops and compares them.
module tb_lcb_rx_packer;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [7:0]  rxData   = 8'h00;
    logic        rxValid  = 1'b0;
    logic [4:0]  rqNumber = 5'd0;
    logic [11:0] wrdOut;
    logic [9:0]  wrdAddr;
    logic        wren;
    logic        pktDone;
    logic [2:0]  pktErr;

    lcb_rx_packer #(
        .BYTES      (14),
        .GAP_CYCLES (400)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .rqNumber (rqNumber),
        .wrdOut   (wrdOut),
        .wrdAddr  (wrdAddr),
        .wren     (wren),
        .pktDone  (pktDone),
        .pktErr   (pktErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [11:0] w;
        logic [9:0]  a;
        logic [2:0]  err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          fin_req  = 1'b0;
    bit          fin_done = 1'b0;
    logic [7:0]  pkt[16];
    logic [11:0] exp_w[8];
    int          per[16];
    int          stb_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: reset values while reset is high, otherwise pop on every output event.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            chk("rst_wren",    32'(wren),    32'd0);
            chk("rst_wrdOut",  32'(wrdOut),  32'd0);
            chk("rst_wrdAddr", 32'(wrdAddr), 32'd0);
            chk("rst_pktDone", 32'(pktDone), 32'd0);
            chk("rst_pktErr",  32'(pktErr),  32'd0);
        end else begin
            if (wren) begin
                chk("wren_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_kind",   32'(e.is_done), 32'd0);
                    chk("wrdOut",    32'(wrdOut),    32'(e.w));
                    chk("wrdAddr",   32'(wrdAddr),   32'(e.a));
                    chk("pktErr_wr", 32'(pktErr),    32'd0);
                end
            end
            if (pktDone) begin
                chk("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_kind",  32'(e.is_done), 32'd1);
                    chk("pktErr",     32'(pktErr),    32'(e.err));
                    chk("done_cycle", 32'(cyc),       32'(e.cyc));
                end
            end
        end
        if (fin_req && !fin_done) begin
            chk("scoreboard_drained", 32'(sb.size()), 32'd0);
            fin_done = 1'b1;
        end
    end

    task automatic load_nominal();
        pkt = '{8'h34, 8'h02, 8'h56, 8'h04, 8'h78, 8'h06, 8'h9A, 8'h08,
                8'hBC, 8'h0A, 8'hDE, 8'h0C, 8'hF0, 8'h0E, 8'h55, 8'h66};
        exp_w = '{12'h234, 12'h456, 12'h678, 12'h89A,
                  12'hABC, 12'hCDE, 12'hEF0, 12'h000};
    endtask

    task automatic set_per();
        for (int i = 0; i < 16; i++) per[i] = 160;
    endtask

    // Sends n bytes; per[i] is the strobe-to-strobe distance to the next byte,
    // last_per the distance after the final byte (to the next call's first byte).
    task automatic send_pkt(input logic [4:0] rq, input int n, input int nw,
                            input logic [2:0] err, input bit want_done, input int last_per);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) rqNumber = rq;
            if ((i % 2 == 1) && (i / 2 < nw))
                sb.push_back('{1'b0, exp_w[i/2], 10'(rq * 7 + i / 2), 3'b000, 0});
            rxData  = pkt[i];
            rxValid = 1'b1;
            stb_cyc = cyc;
            if (want_done && (i == n - 1))
                sb.push_back('{1'b1, 12'h000, 10'h000, err, stb_cyc + 401});
            repeat (4) @(posedge clk);
            #1;
            rxValid  = 1'b0;
            rqNumber = ~rq;
            repeat (((i == n - 1) ? last_per : per[i]) - 5) @(posedge clk);
        end
    endtask

    initial begin
        load_nominal();
        set_per();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;

        // Nominal: rq=3, words at 21..27, clean close.
        send_pkt(5'd3, 14, 7, 3'b000, 1'b1, 420);

        // Short: 9 bytes, 4 writes, closes 401 cycles after the 9th strobe.
        send_pkt(5'd6, 9, 4, 3'b001, 1'b1, 420);

        // Overflow: 16 bytes, last two discarded.
        send_pkt(5'd9, 16, 7, 3'b010, 1'b1, 420);

        // Reserved nibble: hi byte 0xA5 with lo 0x11 writes 0x511.
        pkt[0]   = 8'h11;
        pkt[1]   = 8'hA5;
        exp_w[0] = 12'h511;
        send_pkt(5'd4, 14, 7, 3'b100, 1'b1, 420);
        load_nominal();

        // Gaps of 399 and exactly 400 (strobe on the timeout cycle) stay open.
        per[1] = 399;
        per[2] = 400;
        send_pkt(5'd1, 14, 7, 3'b000, 1'b1, 420);
        set_per();

        // A 401-cycle gap closes the packet; the late byte lands in DONE and
        // starts the next packet.
        send_pkt(5'd2, 3, 1, 3'b001, 1'b1, 401);
        send_pkt(5'd2, 14, 7, 3'b000, 1'b1, 420);

        // Reset after byte 5: no close, then a clean packet at rq=0.
        send_pkt(5'd5, 5, 2, 3'b000, 1'b0, 10);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (600) @(posedge clk);
        send_pkt(5'd0, 14, 7, 3'b000, 1'b1, 420);

        repeat (20) @(posedge clk);
        fin_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
